// File: rtl/reg_file_pkg.sv
// Shared constants and types for the multi-port integer register file.
package reg_file_pkg;

  localparam int XLEN_DEFAULT     = 32;
  localparam int NUM_REGS_DEFAULT = 32;
  localparam int AW_DEFAULT       = $clog2(NUM_REGS_DEFAULT);
  localparam int ZERO_REG         = 0;

  typedef logic [AW_DEFAULT-1:0]   reg_idx_t;
  typedef logic [XLEN_DEFAULT-1:0] xword_t;

endpackage

// File: rtl/reg_file_mp_intf.sv
// Parametrised bundle of all register-file signals; the monitor modport observes everything.
interface reg_file_mp_intf #(
  parameter int XLEN         = 32,
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 1,
  parameter int AW           = $clog2(NUM_REGS)
) (
  input logic clk,
  input logic rst_n
);

  logic [NUM_WR_PORTS-1:0]      wr_en;
  logic [NUM_WR_PORTS*AW-1:0]   wr_reg;
  logic [NUM_WR_PORTS*XLEN-1:0] wr_data;
  logic [NUM_RD_PORTS*AW-1:0]   rd_reg;
  logic [NUM_RD_PORTS*XLEN-1:0] rd_data;
  logic [NUM_RD_PORTS-1:0]      rd_busy;
  logic                         rsv_en;
  logic [AW-1:0]                rsv_reg;

  modport dut (
    input  clk, rst_n, wr_en, wr_reg, wr_data, rd_reg, rsv_en, rsv_reg,
    output rd_data, rd_busy
  );

  modport monitor (
    input clk, rst_n, wr_en, wr_reg, wr_data, rd_reg, rd_data, rd_busy, rsv_en, rsv_reg
  );

endinterface

// File: rtl/reg_busy_tracker.sv
// Per-register busy scoreboard: reserve sets, any write clears, reserve wins a same-cycle tie.
module reg_busy_tracker
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS     = NUM_REGS_DEFAULT,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 1,
  parameter int AW           = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_WR_PORTS-1:0]    wr_en,
  input  logic [NUM_WR_PORTS*AW-1:0] wr_reg,
  input  logic                       rsv_en,
  input  logic [AW-1:0]              rsv_reg,
  input  logic [NUM_RD_PORTS*AW-1:0] rd_reg,
  output logic [NUM_RD_PORTS-1:0]    rd_busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      if (wr_en[p]) busy_d[wr_reg[p*AW +: AW]] = 1'b0;
    end
    // Applied after the clears: a reserve marks a newer producer than the write landing now.
    if (rsv_en) busy_d[rsv_reg] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_comb begin
    rd_busy = '0;
    for (int r = 0; r < NUM_RD_PORTS; r++) begin
      rd_busy[r] = busy_q[rd_reg[r*AW +: AW]];
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with hardwired x0, highest-port-wins writes and optional same-cycle bypass.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int NUM_REGS     = NUM_REGS_DEFAULT,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 1,
  parameter int BYPASS       = 1,
  parameter int AW           = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_WR_PORTS-1:0]      wr_en,
  input  logic [NUM_WR_PORTS*AW-1:0]   wr_reg,
  input  logic [NUM_WR_PORTS*XLEN-1:0] wr_data,
  input  logic [NUM_RD_PORTS*AW-1:0]   rd_reg,
  output logic [NUM_RD_PORTS*XLEN-1:0] rd_data,
  output logic [NUM_RD_PORTS-1:0]      rd_busy,
  input  logic                         rsv_en,
  input  logic [AW-1:0]                rsv_reg
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];

  // Ascending port loop makes the highest enabled port the winner on a shared target.
  always_comb begin
    regs_d = regs_q;
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      if (wr_en[p]) regs_d[wr_reg[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
    end
    regs_d[ZERO_REG] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // regs_d already carries the resolved same-cycle write, so it doubles as the bypass source.
  // Reads are forced to zero during reset so a driven write cannot leak through the bypass.
  always_comb begin
    rd_data = '0;
    for (int r = 0; r < NUM_RD_PORTS; r++) begin
      if (rst_n) begin
        if (BYPASS != 0) rd_data[r*XLEN +: XLEN] = regs_d[rd_reg[r*AW +: AW]];
        else             rd_data[r*XLEN +: XLEN] = regs_q[rd_reg[r*AW +: AW]];
      end
    end
  end

  reg_busy_tracker #(
    .NUM_REGS     (NUM_REGS),
    .NUM_RD_PORTS (NUM_RD_PORTS),
    .NUM_WR_PORTS (NUM_WR_PORTS),
    .AW           (AW)
  ) u_busy (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_reg  (wr_reg),
    .rsv_en  (rsv_en & (rsv_reg != AW'(ZERO_REG))),
    .rsv_reg (rsv_reg),
    .rd_reg  (rd_reg),
    .rd_busy (rd_busy)
  );

endmodule
